// File: rtl/satd_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | satd_ctrl: sequencer for the 8x8 SATD datapath (diff/h-transform, transpose |
// | buffer, v-transform) with column-sum accumulation and rounded SATD result.  |
// | Revision: 1.0                                                               |
// +----------------------------------------------------------------------------+
module satd_ctrl #(
  parameter int N        = 8,
  parameter int H_LAT    = 2,
  parameter int COLSUM_W = 14,
  parameter int SATD_W   = 17
) (
  input  logic                   CLK,
  input  logic                   RST,
  input  logic                   start,
  output logic                   busy,
  input  logic                   in_valid,
  output logic                   in_ready,
  output logic                   diff_en,
  output logic [$clog2(N)-1:0]   row_idx,
  output logic                   buf_shift_in,
  output logic                   buf_shift_out,
  output logic [$clog2(N)-1:0]   col_idx,
  input  logic                   colsum_valid,
  input  logic [COLSUM_W-1:0]    colsum,
  output logic [SATD_W-1:0]      satd,
  output logic                   satd_valid,
  output logic                   err
);

  localparam int                c_IDX_W    = $clog2(N);
  localparam int                c_ACC_W    = SATD_W + 1;
  localparam logic [c_IDX_W:0]  c_CNT_N    = (c_IDX_W+1)'(N);
  localparam logic [c_IDX_W:0]  c_CNT_LAST = (c_IDX_W+1)'(N - 1);
  localparam logic [c_IDX_W-1:0] c_IDX_LAST = c_IDX_W'(N - 1);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_LOAD    = 3'd1,
    S_DRAIN_H = 3'd2,
    S_VERT    = 3'd3,
    S_DRAIN_V = 3'd4,
    S_DONE    = 3'd5
  } state_t;

  state_t               r_state;
  logic [c_IDX_W-1:0]   r_row_cnt;
  logic [c_IDX_W-1:0]   r_col_cnt;
  logic [c_IDX_W:0]     r_shin_cnt;
  logic [c_IDX_W:0]     r_cs_cnt;
  logic [c_ACC_W-1:0]   r_acc;
  logic [H_LAT-1:0]     r_dly;

  logic [c_ACC_W-1:0]   w_acc_next;
  logic [c_ACC_W-1:0]   w_rnd;
  logic                 w_shin_done;
  logic                 w_acc_state;

  assign diff_en      = in_valid & in_ready;
  assign row_idx      = r_row_cnt;
  assign col_idx      = r_col_cnt;
  assign buf_shift_in = r_dly[H_LAT-1];

  assign w_acc_next  = r_acc + c_ACC_W'(colsum);
  assign w_rnd       = w_acc_next + c_ACC_W'(2);
  // Leave DRAIN_H in the same cycle the last row lands so VERT starts right after it.
  assign w_shin_done = (r_shin_cnt == c_CNT_N) || (buf_shift_in && (r_shin_cnt == c_CNT_LAST));
  assign w_acc_state = (r_state == S_VERT) || (r_state == S_DRAIN_V);

  always_ff @(posedge CLK) begin
    if (!RST) begin
      r_state       <= S_IDLE;
      busy          <= 1'b0;
      in_ready      <= 1'b0;
      buf_shift_out <= 1'b0;
      satd_valid    <= 1'b0;
      satd          <= '0;
      err           <= 1'b0;
      r_row_cnt     <= '0;
      r_col_cnt     <= '0;
      r_shin_cnt    <= '0;
      r_cs_cnt      <= '0;
      r_acc         <= '0;
      r_dly         <= '0;
    end else begin
      r_dly[0] <= diff_en;
      for (int i = 1; i < H_LAT; i++) r_dly[i] <= r_dly[i-1];
      satd_valid <= 1'b0;
      if (buf_shift_in && (r_shin_cnt != c_CNT_N)) r_shin_cnt <= r_shin_cnt + (c_IDX_W+1)'(1);

      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_state    <= S_LOAD;
            busy       <= 1'b1;
            in_ready   <= 1'b1;
            r_row_cnt  <= '0;
            r_col_cnt  <= '0;
            r_shin_cnt <= '0;
            r_cs_cnt   <= '0;
            r_acc      <= '0;
            err        <= 1'b0;
          end
        end
        S_LOAD: begin
          if (diff_en) begin
            r_row_cnt <= r_row_cnt + c_IDX_W'(1);
            if (r_row_cnt == c_IDX_LAST) begin
              r_state  <= S_DRAIN_H;
              in_ready <= 1'b0;
            end
          end
        end
        S_DRAIN_H: begin
          if (w_shin_done) begin
            r_state       <= S_VERT;
            buf_shift_out <= 1'b1;
            r_col_cnt     <= '0;
          end
        end
        S_VERT: begin
          r_col_cnt <= r_col_cnt + c_IDX_W'(1);
          if (r_col_cnt == c_IDX_LAST) begin
            r_state       <= S_DRAIN_V;
            buf_shift_out <= 1'b0;
          end
        end
        S_DRAIN_V: ;
        S_DONE: begin
          r_state <= S_IDLE;
          busy    <= 1'b0;
        end
        default: begin
          r_state       <= S_IDLE;
          busy          <= 1'b0;
          in_ready      <= 1'b0;
          buf_shift_out <= 1'b0;
        end
      endcase

      if (colsum_valid && ((r_state == S_IDLE) || (r_state == S_LOAD) || (r_cs_cnt == c_CNT_N)))
        err <= 1'b1;

      // Completion may occur while still in VERT; it overrides the column sequencing above.
      if (colsum_valid && w_acc_state && (r_cs_cnt != c_CNT_N)) begin
        r_acc    <= w_acc_next;
        r_cs_cnt <= r_cs_cnt + (c_IDX_W+1)'(1);
        if (r_cs_cnt == c_CNT_LAST) begin
          r_state       <= S_DONE;
          buf_shift_out <= 1'b0;
          satd          <= SATD_W'(w_rnd >> 2);
          satd_valid    <= 1'b1;
        end
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_satd_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_satd_ctrl: directed self-checking bench for satd_ctrl.                   |
// | Revision: 1.0                                                               |
// +----------------------------------------------------------------------------+
module tb_satd_ctrl;

  localparam int N        = 8;
  localparam int H_LAT    = 2;
  localparam int COLSUM_W = 14;
  localparam int SATD_W   = 17;

  logic                CLK = 1'b0;
  logic                RST = 1'b0;
  logic                start = 1'b0;
  logic                in_valid = 1'b0;
  logic                busy, in_ready, diff_en, buf_shift_in, buf_shift_out;
  logic                satd_valid, err, colsum_valid;
  logic [2:0]          row_idx, col_idx;
  logic [COLSUM_W-1:0] colsum;
  logic [SATD_W-1:0]   satd;

  // Column-sum model: returns auto_val two cycles after each buf_shift_out.
  logic                man_valid = 1'b0;
  logic [COLSUM_W-1:0] man_val = '0;
  logic [COLSUM_W-1:0] auto_val = '0;
  logic                auto_en = 1'b0;
  logic [1:0]          bso_pipe = 2'b00;

  assign colsum_valid = man_valid | (auto_en & bso_pipe[1]);
  assign colsum       = man_valid ? man_val : auto_val;

  satd_ctrl #(.N(N), .H_LAT(H_LAT), .COLSUM_W(COLSUM_W), .SATD_W(SATD_W)) dut (
    .CLK(CLK), .RST(RST), .start(start), .busy(busy),
    .in_valid(in_valid), .in_ready(in_ready), .diff_en(diff_en), .row_idx(row_idx),
    .buf_shift_in(buf_shift_in), .buf_shift_out(buf_shift_out), .col_idx(col_idx),
    .colsum_valid(colsum_valid), .colsum(colsum),
    .satd(satd), .satd_valid(satd_valid), .err(err)
  );

  always #5 CLK = ~CLK;

  int cyc = 0;
  always @(posedge CLK) begin
    cyc      <= cyc + 1;
    bso_pipe <= {bso_pipe[0], buf_shift_out};
  end

  int t0 = 0;
  bit logging = 1'b0;
  int q_de[$], q_ri[$], q_bsi[$], q_bso[$], q_ci[$], q_sv[$];

  always @(negedge CLK) begin
    if (logging) begin
      if (diff_en)       begin q_de.push_back(cyc - t0);  q_ri.push_back(int'(row_idx)); end
      if (buf_shift_in)  q_bsi.push_back(cyc - t0);
      if (buf_shift_out) begin q_bso.push_back(cyc - t0); q_ci.push_back(int'(col_idx)); end
      if (satd_valid)    q_sv.push_back(cyc - t0);
    end
  end

  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input string tag, input longint got, input longint exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge CLK);
    #1;
  endtask

  task automatic run_block(input bit gaps, input int val, input bit inj_load,
                           input bit inj9, input bit start_mid, input bit rst_mid);
    int rel;
    q_de.delete(); q_ri.delete(); q_bsi.delete(); q_bso.delete(); q_ci.delete(); q_sv.delete();
    auto_val = COLSUM_W'(val);
    auto_en  = 1'b1;
    t0       = cyc;
    logging  = 1'b1;
    start    = 1'b1;
    in_valid = !gaps;
    tick(1);
    start    = 1'b0;
    in_valid = 1'b0;
    for (int k = 0; k < 100 && q_de.size() < N; k++) begin
      in_valid  = gaps ? ~in_valid : 1'b1;
      man_valid = inj_load && (k == 2);
      man_val   = COLSUM_W'(1000);
      tick(1);
    end
    in_valid  = 1'b0;
    man_valid = 1'b0;
    for (int k = 0; k < 100 && q_sv.size() == 0; k++) begin
      rel       = cyc - t0;
      start     = start_mid && (rel == 14);
      man_valid = inj9 && (rel == 21);
      man_val   = COLSUM_W'(5000);
      if (rst_mid && rel == 15) begin
        chk("rst_mid_col_idx", col_idx, 4);
        RST     = 1'b0;
        auto_en = 1'b0;
        tick(1);
        RST     = 1'b1;
        break;
      end
      tick(1);
    end
    start     = 1'b0;
    man_valid = 1'b0;
    if (!rst_mid) chk("done_seen", q_sv.size(), 1);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset with busy inputs toggling around it.
    RST = 1'b0; in_valid = 1'b1; man_valid = 1'b1; man_val = COLSUM_W'(123);
    tick(3);
    chk("rst_busy", busy, 0);
    chk("rst_in_ready", in_ready, 0);
    chk("rst_diff_en", diff_en, 0);
    chk("rst_shift", {buf_shift_in, buf_shift_out}, 0);
    chk("rst_idx", {row_idx, col_idx}, 0);
    chk("rst_satd", satd, 0);
    chk("rst_satd_valid", satd_valid, 0);
    chk("rst_err", err, 0);
    man_valid = 1'b0;
    RST = 1'b1;
    tick(2);
    chk("idle_in_ready", in_ready, 0);
    chk("idle_diff_en", diff_en, 0);
    chk("idle_err", err, 0);
    in_valid = 1'b0;
    tick(1);

    // Nominal, colsum=100 -> satd 200.
    run_block(0, 100, 0, 0, 0, 0);
    chk("nom_busy_c22", busy, 0);
    chk("nom_cycle_now", cyc - t0, 22);
    chk("nom_de_cnt", q_de.size(), 8);
    for (int i = 0; i < q_de.size() && i < N; i++) begin
      chk("nom_de_cyc", q_de[i], i + 1);
      chk("nom_row_idx", q_ri[i], i);
    end
    chk("nom_bsi_cnt", q_bsi.size(), 8);
    for (int i = 0; i < q_bsi.size() && i < N; i++) chk("nom_bsi_cyc", q_bsi[i], i + 3);
    chk("nom_bso_cnt", q_bso.size(), 8);
    for (int i = 0; i < q_bso.size() && i < N; i++) begin
      chk("nom_bso_cyc", q_bso[i], i + 11);
      chk("nom_col_idx", q_ci[i], i);
    end
    if (q_sv.size() > 0) chk("nom_sv_cyc", q_sv[0], 21);
    chk("nom_satd", satd, 200);
    chk("nom_err", err, 0);
    tick(3);

    // in_valid gaps, colsum=37 -> (296+2)>>2 = 74.
    run_block(1, 37, 0, 0, 0, 0);
    chk("gap_de_cnt", q_de.size(), 8);
    for (int i = 0; i < q_de.size() && i < N; i++) begin
      chk("gap_de_cyc", q_de[i], 1 + 2 * i);
      chk("gap_row_idx", q_ri[i], i);
    end
    chk("gap_bsi_cnt", q_bsi.size(), 8);
    for (int i = 0; i < q_bsi.size() && i < N; i++) chk("gap_bsi_cyc", q_bsi[i], 3 + 2 * i);
    chk("gap_satd", satd, 74);
    tick(3);

    run_block(0, 16383, 0, 0, 0, 0);
    chk("max_satd", satd, 32766);
    chk("max_err", err, 0);
    tick(3);

    run_block(0, 1, 0, 0, 0, 0);
    chk("ones_satd", satd, 2);
    tick(3);

    // Stray colsum during LOAD is flagged and dropped.
    run_block(0, 100, 1, 0, 0, 0);
    chk("load_err", err, 1);
    chk("load_satd", satd, 200);
    tick(3);

    // start mid-VERT ignored; the fresh start clears err.
    run_block(0, 50, 0, 0, 1, 0);
    chk("smid_err_cleared", err, 0);
    chk("smid_satd", satd, 100);
    chk("smid_de_cnt", q_de.size(), 8);
    chk("smid_bso_cnt", q_bso.size(), 8);
    if (q_sv.size() > 0) chk("smid_sv_cyc", q_sv[0], 21);
    tick(3);

    // 9th colsum lands in DONE.
    run_block(0, 1, 0, 1, 0, 0);
    tick(2);
    chk("ninth_err", err, 1);
    chk("ninth_satd", satd, 2);
    tick(3);

    // Reset in the middle of VERT at col_idx 4.
    run_block(0, 100, 0, 0, 0, 1);
    chk("rmid_busy", busy, 0);
    chk("rmid_bso", buf_shift_out, 0);
    chk("rmid_satd", satd, 0);
    chk("rmid_in_ready", in_ready, 0);
    tick(10);
    begin
      int late = 0;
      foreach (q_bso[i]) if (q_bso[i] > 15) late++;
      foreach (q_bsi[i]) if (q_bsi[i] > 15) late++;
      chk("rmid_late_pulses", late, 0);
    end
    chk("rmid_bso_cnt", q_bso.size(), 5);
    chk("rmid_no_result", q_sv.size(), 0);
    chk("rmid_err", err, 0);

    run_block(0, 100, 0, 0, 0, 0);
    chk("fresh_satd", satd, 200);
    chk("fresh_err", err, 0);
    tick(2);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
